// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the fabric configuration loader: target map, sizes and FSM states.
package fpga_cfg_pkg;

    localparam int N_TARGETS = 22;
    localparam int N_WORDS   = 33;
    localparam int CFG_SEL_W = 5;

    // Bit i is set when target i is a LUT tile (two words) rather than a switch box (one word).
    localparam logic [N_TARGETS-1:0] TARGET_IS_LUT = 22'h0F_F0E0;

    localparam logic [CFG_SEL_W-1:0] SB_11 = 5'd0;
    localparam logic [CFG_SEL_W-1:0] SB_12 = 5'd1;
    localparam logic [CFG_SEL_W-1:0] SB_13 = 5'd2;
    localparam logic [CFG_SEL_W-1:0] SB_14 = 5'd3;
    localparam logic [CFG_SEL_W-1:0] SB_15 = 5'd4;
    localparam logic [CFG_SEL_W-1:0] LT_21 = 5'd5;
    localparam logic [CFG_SEL_W-1:0] LT_22 = 5'd6;
    localparam logic [CFG_SEL_W-1:0] LT_23 = 5'd7;
    localparam logic [CFG_SEL_W-1:0] SB_31 = 5'd8;
    localparam logic [CFG_SEL_W-1:0] SB_32 = 5'd9;
    localparam logic [CFG_SEL_W-1:0] SB_33 = 5'd10;
    localparam logic [CFG_SEL_W-1:0] SB_34 = 5'd11;
    localparam logic [CFG_SEL_W-1:0] LT_41 = 5'd12;
    localparam logic [CFG_SEL_W-1:0] LT_42 = 5'd13;
    localparam logic [CFG_SEL_W-1:0] LT_43 = 5'd14;
    localparam logic [CFG_SEL_W-1:0] LT_51 = 5'd15;
    localparam logic [CFG_SEL_W-1:0] LT_52 = 5'd16;
    localparam logic [CFG_SEL_W-1:0] LT_53 = 5'd17;
    localparam logic [CFG_SEL_W-1:0] LT_54 = 5'd18;
    localparam logic [CFG_SEL_W-1:0] LT_55 = 5'd19;
    localparam logic [CFG_SEL_W-1:0] SB_61 = 5'd20;
    localparam logic [CFG_SEL_W-1:0] SB_62 = 5'd21;

    localparam logic [CFG_SEL_W-1:0] LAST_TARGET = SB_62;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_LO = 3'd1,
        LOAD_HI = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } cfg_state_t;

    function automatic logic is_lut(input logic [CFG_SEL_W-1:0] t);
        return TARGET_IS_LUT[t];
    endfunction

endpackage

// File: rtl/fpga_cfg_if.sv
// Boot-stream and configuration-bus signals between a boot source and the loader.
interface fpga_cfg_if;
    import fpga_cfg_pkg::*;

    logic                 start;
    logic [31:0]          in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [CFG_SEL_W-1:0] cfg_sel;
    logic [32:0]          cfg_data;
    logic                 cfg_we;
    logic                 done;
    logic                 error;
    logic                 fabric_en;
    cfg_state_t           state;

    // A word moves on the rising edge where in_valid && in_ready; the source holds in_data
    // stable while in_valid is high and unaccepted, and in_ready never looks at in_valid.
    modport master (
        output start, in_data, in_valid,
        input  in_ready, cfg_sel, cfg_data, cfg_we, done, error, fabric_en, state
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, cfg_sel, cfg_data, cfg_we, done, error, fabric_en, state
    );

endinterface

// File: rtl/fpga_cfg_loader.sv
// Streams the 33-word image into the 22 fabric targets and enables the fabric once committed.
// Optional trailing XOR checksum word is compiled in with FPGA_CFG_CHECKSUM_EN.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    fpga_cfg_if.slave bus
);

    cfg_state_t           state_q, state_d;
    logic [CFG_SEL_W-1:0] tgt_q, tgt_d;
    logic [31:0]          lo_q, lo_d;
    logic [CFG_SEL_W-1:0] sel_q, sel_d;
    logic [32:0]          data_q, data_d;
    logic                 we_q, we_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 last_tgt;
    logic                 wr_fire;
    logic [32:0]          wr_val;
`ifdef FPGA_CFG_CHECKSUM_EN
    logic [31:0]          xor_q, xor_d;
    logic                 err_q, err_d;
`endif

    // start forces a restart, so a word offered in that cycle is left with the source.
    assign bus.in_ready = (state_q == LOAD_LO || state_q == LOAD_HI || state_q == CHECK)
                          && !bus.start;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_tgt     = (tgt_q == LAST_TARGET);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        lo_d    = lo_q;
        sel_d   = sel_q;
        data_d  = data_q;
        we_d    = 1'b0;
        done_d  = done_q;
        wr_fire = 1'b0;
        wr_val  = '0;
`ifdef FPGA_CFG_CHECKSUM_EN
        xor_d   = xor_q;
        err_d   = err_q;
`endif
        if (bus.start) begin
            state_d = LOAD_LO;
            tgt_d   = '0;
            lo_d    = '0;
            done_d  = 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
            xor_d   = '0;
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD_LO: begin
                    if (accept) begin
`ifdef FPGA_CFG_CHECKSUM_EN
                        xor_d = xor_q ^ bus.in_data;
`endif
                        if (is_lut(tgt_q)) begin
                            lo_d    = bus.in_data;
                            state_d = LOAD_HI;
                        end else begin
                            wr_fire = 1'b1;
                            wr_val  = {1'b0, bus.in_data};
                        end
                    end
                end
                LOAD_HI: begin
                    if (accept) begin
`ifdef FPGA_CFG_CHECKSUM_EN
                        xor_d = xor_q ^ bus.in_data;
`endif
                        // Only bit 0 of the high word is meaningful for a LUT.
                        wr_fire = 1'b1;
                        wr_val  = {bus.in_data[0], lo_q};
                    end
                end
`ifdef FPGA_CFG_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (bus.in_data == xor_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ERROR;
                            err_d   = 1'b1;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase

            if (wr_fire) begin
                we_d   = 1'b1;
                sel_d  = tgt_q;
                data_d = wr_val;
                tgt_d  = tgt_q + CFG_SEL_W'(1);
                if (last_tgt) begin
`ifdef FPGA_CFG_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = LOAD_LO;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            lo_q    <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
            xor_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            lo_q    <= lo_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            we_q    <= we_d;
            done_q  <= done_d;
`ifdef FPGA_CFG_CHECKSUM_EN
            xor_q   <= xor_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.cfg_sel   = sel_q;
    assign bus.cfg_data  = data_q;
    assign bus.cfg_we    = we_q;
    assign bus.done      = done_q;
    assign bus.fabric_en = done_q;
    assign bus.state     = state_q;
`ifdef FPGA_CFG_CHECKSUM_EN
    assign bus.error     = err_q;
`else
    assign bus.error     = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader: random streams against a word-list model of the image.
module tb_fpga_cfg_loader;
    import fpga_cfg_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   test_id = 0;
    logic [31:0] img [33];

    fpga_cfg_if bus ();

    fpga_cfg_loader dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tb_is_lut(input int t);
        return (t >= 5 && t <= 7) || (t >= 12 && t <= 19);
    endfunction

    // Which target word k of an image belongs to, and whether it is that target's last word.
    function automatic void word_role(input int k, output int t, output bit fin);
        int pos;
        int nw;
        pos = 0;
        t   = -1;
        fin = 1'b0;
        for (int i = 0; i < 22; i++) begin
            nw = tb_is_lut(i) ? 2 : 1;
            if (t < 0 && k < pos + nw) begin
                t   = i;
                fin = (k == pos + nw - 1);
            end
            pos += nw;
        end
    endfunction

    // Reference model and comparison: checks outputs each falling edge, then predicts the next edge.
    initial begin : compare
        logic [31:0] m_words [$];
        bit          m_loading, m_done, m_err, m_we, exp_ready, fin;
        logic [4:0]  m_sel;
        logic [32:0] m_data;
        logic [31:0] w;
        int          k, t;
        m_loading = 0; m_done = 0; m_err = 0; m_we = 0; m_sel = '0; m_data = '0;
        forever begin
            @(negedge clock or negedge reset_n);
            if (!reset_n) begin
                #1;
                check("rst_in_ready", bus.in_ready, 0);
                check("rst_cfg_sel", bus.cfg_sel, 0);
                check("rst_cfg_data", bus.cfg_data, 0);
                check("rst_cfg_we", bus.cfg_we, 0);
                check("rst_done", bus.done, 0);
                check("rst_error", bus.error, 0);
                check("rst_fabric_en", bus.fabric_en, 0);
                m_words.delete();
                m_loading = 0; m_done = 0; m_err = 0; m_we = 0; m_sel = '0; m_data = '0;
            end else begin
                exp_ready = m_loading && !bus.start;
                check("in_ready", bus.in_ready, exp_ready);
                check("cfg_we", bus.cfg_we, m_we);
                check("cfg_sel", bus.cfg_sel, m_sel);
                check("cfg_data", bus.cfg_data, m_data);
                check("done", bus.done, m_done);
                check("fabric_en", bus.fabric_en, m_done);
                check("error", bus.error, m_err);
                if (m_we && test_id == 1 && m_sel == 5'd5)  check("pin_t1_sel5", m_data, 33'h0_1000_0005);
                if (m_we && test_id == 1 && m_sel == 5'd12) check("pin_t1_sel12", m_data, 33'h0_1000_000F);
                if (m_we && test_id == 1 && m_sel == 5'd15) check("pin_t1_sel15", m_data, 33'h0_1000_0015);
                if (m_we && test_id == 1 && m_sel == 5'd21) check("pin_t1_sel21", m_data, 33'h0_1000_0020);
                if (m_we && test_id == 2 && m_sel == 5'd5)  check("pin_t2_sel5", m_data, 33'h1_DEAD_BEEF);
                m_we = 0;
                if (bus.start) begin
                    m_words.delete();
                    m_loading = 1; m_done = 0; m_err = 0;
                end else if (exp_ready && bus.in_valid) begin
                    w = bus.in_data;
                    m_words.push_back(w);
                    k = m_words.size() - 1;
                    word_role(k, t, fin);
                    if (fin) begin
                        m_we   = 1;
                        m_sel  = t[4:0];
                        m_data = tb_is_lut(t) ? {w[0], m_words[k-1]} : {1'b0, w};
                    end
`ifdef FPGA_CFG_CHECKSUM_EN
                    if (k == 33) begin
                        logic [31:0] x;
                        x = '0;
                        for (int i = 0; i < 33; i++) x ^= m_words[i];
                        if (w == x) m_done = 1; else m_err = 1;
                        m_loading = 0;
                    end
`else
                    if (k == 32) begin
                        m_done    = 1;
                        m_loading = 0;
                    end
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic v);
        bus.in_valid = v;
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        bit acc;
        int budget;
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 100) begin
            @(negedge clock);
            acc = bus.in_ready;
            tick();
            budget++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: word %0h not accepted, required in_ready=1 within 100 cycles", w);
        end
    endtask

    task automatic send_words(input int n, input int gap_max);
        for (int k = 0; k < n; k++) send_word(img[k], gap_max);
    endtask

    task automatic rand_img();
        for (int k = 0; k < 33; k++) img[k] = $urandom;
    endtask

`ifdef FPGA_CFG_CHECKSUM_EN
    function automatic logic [31:0] img_xor();
        logic [31:0] x;
        x = '0;
        for (int k = 0; k < 33; k++) x ^= img[k];
        return x;
    endfunction
`endif

    // Full image plus, when the checksum is built in, its correct trailing word.
    task automatic send_image(input int gap_max);
        send_words(33, gap_max);
`ifdef FPGA_CFG_CHECKSUM_EN
        send_word(img_xor(), gap_max);
`endif
    endtask

    initial begin : driver
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        idle(4, 1'b1);

        test_id = 1;
        for (int k = 0; k < 33; k++) img[k] = 32'h1000_0000 + k;
        pulse_start();
        send_image(0);
        idle(4, 1'b1);

        test_id = 2;
        rand_img();
        img[5] = 32'hDEAD_BEEF;
        img[6] = 32'hFFFF_FFFF;
        pulse_start();
        send_image(0);
        idle(3, 1'b0);

        test_id = 3;
        repeat (3) begin
            rand_img();
            pulse_start();
            send_image(3);
            idle(3, 1'b1);
        end

        test_id = 4;
        rand_img();
        pulse_start();
        send_words(16, 1);
        pulse_start();
        rand_img();
        send_image(2);
        idle(3, 1'b0);

        test_id = 5;
        rand_img();
        pulse_start();
        send_words(10, 0);
        #2;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        bus.in_data = img[10];
        idle(6, 1'b1);
        pulse_start();
        send_image(1);
        idle(3, 1'b0);

`ifdef FPGA_CFG_CHECKSUM_EN
        test_id = 6;
        rand_img();
        pulse_start();
        send_words(33, 0);
        send_word(img_xor() ^ 32'h1, 0);
        idle(4, 1'b1);
        pulse_start();
        idle(2, 1'b0);
        send_image(1);
        idle(3, 1'b0);
`endif

        idle(5, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
